icache: RTL and testbench

Direct-mapped, one-word-per-block instruction cache serving the datapath side of the instruction fetch interface. It answers `imemREN` and `imemaddr` with `ihit` and `imemload`. On a miss it issues a single-word read to the memory controller and holds the datapath stalled until that read fills the block. It sits between the pipeline's fetch stage and the memory controller's instruction port.

---
 rtl/icache_if.sv | 22 ++
 rtl/icache.sv | 114 +++++++++++
 tb/tb_icache.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Fetch-side bundle for icache: datapath request/response plus the
// memory-controller instruction read port.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-block, read-only instruction cache.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  icache_if.slave     bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t          state, next_state;
  logic [SETS-1:0] valid;
  logic [TW-1:0]   tags [SETS];
  logic [31:0]     data [SETS];
  logic [31:0]     miss_addr;

  logic [IW-1:0]   idx, fill_idx;
  logic [TW-1:0]   tag, fill_tag;
  logic            lookup_hit;
  logic            miss, fill;
  logic            unused_addr_bits;

  assign idx      = bus.imemaddr[2+IW-1:2];
  assign tag      = bus.imemaddr[31:2+IW];
  assign fill_idx = miss_addr[2+IW-1:2];
  assign fill_tag = miss_addr[31:2+IW];

  assign lookup_hit       = valid[idx] && (tags[idx] == tag);
  assign unused_addr_bits = ^bus.imemaddr[1:0];

  always_comb begin
    next_state   = state;
    miss         = 1'b0;
    fill         = 1'b0;
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    case (state)
      IDLE: begin
        if (bus.imemREN) begin
          if (lookup_hit) begin
            bus.ihit     = 1'b1;
            bus.imemload = data[idx];
          end else begin
            miss       = 1'b1;
            next_state = FETCH;
          end
        end
      end
      FETCH: begin
        // The fill is committed to miss_addr regardless of what the datapath does now
        bus.iREN  = 1'b1;
        bus.iaddr = miss_addr;
        if (!bus.iwait) begin
          fill       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      valid     <= '0;
      miss_addr <= '0;
    end else begin
      state <= next_state;
      if (miss) begin
        miss_addr <= {bus.imemaddr[31:2], 2'b00};
      end
      if (fill) begin
        valid[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag/data need no reset: they are only meaningful behind a set valid bit
  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= bus.iload;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (bus.ihit && (hit_count != '1)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss && (miss_count != '1)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus queues expected hits and fills,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_icache;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } hit_exp_t;

  typedef struct {
    logic [31:0] addr;
    int          ncyc;
  } fill_exp_t;

  logic CLK;
  logic nRST;
  int   cyc;
  int   lat;
  int   wcnt;
  int   run;
  int   tests;
  int   fails;

  hit_exp_t  hq[$];
  fill_exp_t fq[$];

  icache_if bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache #(.SETS(16)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .bus        (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc++;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h0051_3093;
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory model: holds iwait for lat cycles of each read
  always_comb begin
    bus.iwait = bus.iREN && (wcnt < lat);
    bus.iload = bus.iREN ? mem_word(bus.iaddr) : 32'h0;
  end

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) wcnt <= 0;
    else if (bus.iREN && bus.iwait) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (nRST) begin
      if (bus.ihit) begin
        if (hq.size() == 0) begin
          check("unexpected_hit", 32'h1, 32'h0);
        end else begin
          hit_exp_t h;
          h = hq.pop_front();
          check("hit_cycle", cyc, h.cyc);
          check("hit_data", bus.imemload, h.data);
        end
      end
      if (bus.iREN) begin
        run++;
        check("fetch_quiet", {bus.ihit, bus.imemload[30:0]}, 32'h0);
        if (!bus.iwait) begin
          if (fq.size() == 0) begin
            check("unexpected_fill", 32'h1, 32'h0);
          end else begin
            fill_exp_t f;
            f = fq.pop_front();
            check("fill_iaddr", bus.iaddr, f.addr);
            check("fill_iren_cycles", run, f.ncyc);
          end
          run = 0;
        end
      end else begin
        run = 0;
      end
    end else begin
      run = 0;
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the expected hit
  task automatic access(input logic [31:0] addr, input int w, input bit miss,
                        input logic [31:0] data);
    int n;
    lat = w;
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    n = miss ? w + 2 : 0;
    hq.push_back('{cyc + n, data});
    if (miss) fq.push_back('{{addr[31:2], 2'b00}, w + 1});
    repeat (n + 1) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    bus.imemREN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    int c;
    tests = 0;
    fails = 0;
    cyc   = 0;
    lat   = 0;
    run   = 0;
    nRST  = 1'b0;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h40;

    // Reset state with a pending request on the bus
    repeat (2) @(posedge CLK);
    #2;
    check("rst_ihit", bus.ihit, 32'h0);
    check("rst_imemload", bus.imemload, 32'h0);
    check("rst_iREN", bus.iREN, 32'h0);
    check("rst_iaddr", bus.iaddr, 32'h0);
    bus.imemREN = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    // Cold miss, then warm hit on a different byte offset of the same word
    access(32'h40, 2, 1'b1, 32'h0051_3093);
    bus.imemaddr = 32'h42;
    #1;
    check("warm_iREN", bus.iREN, 32'h0);
    hq.push_back('{cyc, 32'h0051_3093});
    @(posedge CLK);
    #1;

    // Conflict on index 0
    access(32'h80, 1, 1'b1, mem_word(32'h80));
    access(32'h80, 0, 1'b0, mem_word(32'h80));
    access(32'h40, 0, 1'b1, 32'h0051_3093);
    access(32'h100, 0, 1'b1, mem_word(32'h100));

    // Address change mid-fetch: fill must still target 0x40
    lat = 3;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h40;
    c = cyc;
    fq.push_back('{32'h40, 4});
    @(posedge CLK);
    #1;
    bus.imemaddr = 32'h100;
    bus.imemREN  = 1'b0;
    #1;
    check("midfetch_iaddr_a", bus.iaddr, 32'h40);
    @(posedge CLK);
    #1;
    bus.imemREN = 1'b1;
    #1;
    check("midfetch_iaddr_b", bus.iaddr, 32'h40);
    repeat (2) @(posedge CLK);
    #1;
    lat = 1;
    fq.push_back('{32'h100, 2});
    hq.push_back('{c + 8, mem_word(32'h100)});
    repeat (5) @(posedge CLK);
    #1;
    bus.imemREN = 1'b0;

    // Reset while the memory is still stalling
    lat = 5;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h80;
    repeat (2) @(posedge CLK);
    #1;
    check("prerst_iREN", bus.iREN, 32'h1);
    nRST = 1'b0;
    bus.imemREN = 1'b0;
    #1;
    check("midfill_rst_iREN", bus.iREN, 32'h0);
    check("midfill_rst_iaddr", bus.iaddr, 32'h0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    access(32'h40, 1, 1'b1, 32'h0051_3093);
    bus.imemREN = 1'b0;

`ifdef ICACHE_STATS_EN
    do_reset();
    access(32'h0, 0, 1'b1, mem_word(32'h0));
    access(32'h4, 0, 1'b1, mem_word(32'h4));
    access(32'h8, 0, 1'b1, mem_word(32'h8));
    access(32'h0, 0, 1'b0, mem_word(32'h0));
    access(32'h4, 0, 1'b0, mem_word(32'h4));
    bus.imemREN = 1'b0;
    @(posedge CLK);
    #1;
    check("miss_count", miss_count, 32'd3);
    check("hit_count", hit_count, 32'd5);
    force dut.hit_count  = 32'hFFFF_FFFF;
    force dut.miss_count = 32'hFFFF_FFFF;
    @(posedge CLK);
    #1;
    release dut.hit_count;
    release dut.miss_count;
    access(32'hC, 0, 1'b1, mem_word(32'hC));
    bus.imemREN = 1'b0;
    @(posedge CLK);
    #1;
    check("hit_count_sat", hit_count, 32'hFFFF_FFFF);
    check("miss_count_sat", miss_count, 32'hFFFF_FFFF);
`endif

    repeat (3) @(posedge CLK);
    #1;
    check("hit_queue_drained", hq.size(), 32'd0);
    check("fill_queue_drained", fq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
